// File: rtl/rs_pkg.sv
// Shared widths, the reservation-station entry record and small helpers
// used by the rs_bank slice.
package rs_pkg;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 4;
   localparam int OP_W   = 3;

   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] vj;
      logic [TAG_W-1:0]  qj;
      logic [DATA_W-1:0] vk;
      logic [TAG_W-1:0]  qk;
      logic [TAG_W-1:0]  dest;
   } rs_entry_t;

   function automatic logic entry_ready(input rs_entry_t e);
      return e.valid && (e.qj == TAG_NONE) && (e.qk == TAG_NONE);
   endfunction

endpackage

// File: rtl/rs_bank_if.sv
// Issue, CDB and dispatch signals of the reservation station bank.
// The bank itself takes the slave view.
interface rs_bank_if;

   logic                      issue_valid;
   logic                      issue_ready;
   logic [rs_pkg::OP_W-1:0]   issue_op;
   logic [rs_pkg::DATA_W-1:0] issue_vj;
   logic [rs_pkg::TAG_W-1:0]  issue_qj;
   logic [rs_pkg::DATA_W-1:0] issue_vk;
   logic [rs_pkg::TAG_W-1:0]  issue_qk;
   logic [rs_pkg::TAG_W-1:0]  issue_dest;

   logic                      cdb_valid;
   logic [rs_pkg::TAG_W-1:0]  cdb_tag;
   logic [rs_pkg::DATA_W-1:0] cdb_data;

   logic                      disp_valid;
   logic                      disp_ready;
   logic [rs_pkg::OP_W-1:0]   disp_op;
   logic [rs_pkg::DATA_W-1:0] disp_vj;
   logic [rs_pkg::DATA_W-1:0] disp_vk;
   logic [rs_pkg::TAG_W-1:0]  disp_dest;

   modport slave (
      input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk, issue_dest,
      input  cdb_valid, cdb_tag, cdb_data,
      input  disp_ready,
      output issue_ready,
      output disp_valid, disp_op, disp_vj, disp_vk, disp_dest
   );

   modport master (
      output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk, issue_dest,
      output cdb_valid, cdb_tag, cdb_data,
      output disp_ready,
      input  issue_ready,
      input  disp_valid, disp_op, disp_vj, disp_vk, disp_dest
   );

endinterface

// File: rtl/rs_entry.sv
// One reservation-station slot: holds the entry and captures CDB results
// for pending operands, both on write (bypass) and while waiting.
module rs_entry
   import rs_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              we,
   input  logic              free,
   input  rs_entry_t         wdata,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output rs_entry_t         entry
);

   rs_entry_t nxt;
   logic      snoop;

   assign snoop = cdb_valid && (cdb_tag != TAG_NONE);

   always_comb begin
      // NOTE: nxt defaults to the held entry so every path assigns it and no latch is inferred.
      nxt = entry;
      if (we) begin
         nxt       = wdata;
         nxt.valid = 1'b1;
      end else if (free) begin
         nxt.valid = 1'b0;
      end
      // Same compare serves the issue bypass and the wakeup of a waiting entry.
      if (nxt.valid && snoop) begin
         if (nxt.qj == cdb_tag) begin
            nxt.vj = cdb_data;
            nxt.qj = TAG_NONE;
         end
         if (nxt.qk == cdb_tag) begin
            nxt.vk = cdb_data;
            nxt.qk = TAG_NONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the whole slot is reset, not just valid, so disp_* read back as zero after reset.
      if (!rst_n) begin
         entry <= '0;
      end else if (flush) begin
         entry <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all slots update from the same pre-edge values.
         entry <= nxt;
      end
   end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station: allocates free slots, tracks issue order
// in an age matrix and dispatches the oldest ready entry to one FU.
module rs_bank
   import rs_pkg::*;
#(
   parameter  int N_ENTRY = 4,
   localparam int CNT_W   = $clog2(N_ENTRY + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   rs_bank_if.slave         bus,
   output logic [CNT_W-1:0] busy_cnt
);

   rs_entry_t ent [N_ENTRY];
   rs_entry_t wdata;

   logic [N_ENTRY-1:0] valid;
   logic [N_ENTRY-1:0] ready;
   logic [N_ENTRY-1:0] free_oh;
   logic [N_ENTRY-1:0] sel;
   logic [N_ENTRY-1:0] we;
   logic [N_ENTRY-1:0] free;
   logic               free_found;
   logic               do_issue;
   logic               do_disp;

   // age[j][i] set means slot j was issued before slot i; diagonal stays 0.
   logic [N_ENTRY-1:0][N_ENTRY-1:0] age;

   always_comb begin
      valid = '0;
      ready = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         valid[i] = ent[i].valid;
         ready[i] = entry_ready(ent[i]);
      end
   end

   always_comb begin
      free_oh    = '0;
      free_found = 1'b0;
      for (int i = 0; i < N_ENTRY; i++) begin
         if (!valid[i] && !free_found) begin
            free_oh[i] = 1'b1;
            free_found = 1'b1;
         end
      end
   end

   assign bus.issue_ready = ~&valid;
   assign do_issue        = bus.issue_valid && bus.issue_ready;

   // A ready slot is selected only if no older slot is also ready.
   always_comb begin
      sel = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         sel[i] = ready[i];
         for (int j = 0; j < N_ENTRY; j++) begin
            if (ready[j] && age[j][i]) sel[i] = 1'b0;
         end
      end
   end

   assign bus.disp_valid = |ready;
   assign do_disp        = bus.disp_valid && bus.disp_ready;

   assign we   = free_oh & {N_ENTRY{do_issue}};
   assign free = sel & {N_ENTRY{bus.disp_ready}};

   assign wdata = '{valid: 1'b1,
                    op:    bus.issue_op,
                    vj:    bus.issue_vj,
                    qj:    bus.issue_qj,
                    vk:    bus.issue_vk,
                    qk:    bus.issue_qk,
                    dest:  bus.issue_dest};

   for (genvar g = 0; g < N_ENTRY; g++) begin : g_slot
      rs_entry u_entry (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .we        (we[g]),
         .free      (free[g]),
         .wdata     (wdata),
         .cdb_valid (bus.cdb_valid),
         .cdb_tag   (bus.cdb_tag),
         .cdb_data  (bus.cdb_data),
         .entry     (ent[g])
      );
   end

   always_comb begin
      bus.disp_op   = '0;
      bus.disp_vj   = '0;
      bus.disp_vk   = '0;
      bus.disp_dest = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         if (sel[i]) begin
            bus.disp_op   = ent[i].op;
            bus.disp_vj   = ent[i].vj;
            bus.disp_vk   = ent[i].vk;
            bus.disp_dest = ent[i].dest;
         end
      end
   end

   // A new entry is younger than every currently valid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age <= '0;
      end else if (flush) begin
         age <= '0;
      end else if (do_issue) begin
         for (int i = 0; i < N_ENTRY; i++) begin
            if (we[i]) begin
               for (int j = 0; j < N_ENTRY; j++) begin
                  age[i][j] <= 1'b0;
                  age[j][i] <= valid[j];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= '0;
      end else if (flush) begin
         busy_cnt <= '0;
      end else begin
         case ({do_issue, do_disp})
            2'b10:   busy_cnt <= busy_cnt + CNT_W'(1);
            2'b01:   busy_cnt <= busy_cnt - CNT_W'(1);
            default: busy_cnt <= busy_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against an issue-order queue model.
module tb_rs_bank;
   import rs_pkg::*;

   localparam int N = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       flush;
   logic [2:0] busy_cnt;
   int         checks = 0;
   int         errors = 0;

   rs_bank_if bus ();

   rs_bank #(.N_ENTRY(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .bus      (bus),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush           = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_op    = '0;
      bus.issue_vj    = '0;
      bus.issue_qj    = '0;
      bus.issue_vk    = '0;
      bus.issue_qk    = '0;
      bus.issue_dest  = '0;
      bus.cdb_valid   = 1'b0;
      bus.cdb_tag     = '0;
      bus.cdb_data    = '0;
      bus.disp_ready  = 1'b0;
   endtask

   task automatic set_issue(input logic [2:0] op, input logic [31:0] vj, input logic [3:0] qj,
                            input logic [31:0] vk, input logic [3:0] qk, input logic [3:0] dest);
      bus.issue_valid = 1'b1;
      bus.issue_op    = op;
      bus.issue_vj    = vj;
      bus.issue_qj    = qj;
      bus.issue_vk    = vk;
      bus.issue_qk    = qk;
      bus.issue_dest  = dest;
   endtask

   task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = tag;
      bus.cdb_data  = data;
   endtask

   task automatic check_out(input string name, input logic ir, input logic dv, input logic [2:0] op,
                            input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest,
                            input logic [2:0] cnt);
      check({name, "_issue_ready"}, 32'(bus.issue_ready), 32'(ir));
      check({name, "_disp_valid"}, 32'(bus.disp_valid), 32'(dv));
      check({name, "_busy_cnt"}, 32'(busy_cnt), 32'(cnt));
      if (dv) begin
         check({name, "_disp_op"}, 32'(bus.disp_op), 32'(op));
         check({name, "_disp_vj"}, bus.disp_vj, vj);
         check({name, "_disp_vk"}, bus.disp_vk, vk);
         check({name, "_disp_dest"}, 32'(bus.disp_dest), 32'(dest));
      end
   endtask

   // Directed vectors: inputs for one cycle, expected outputs after the edge.
   typedef struct {
      logic        fl;
      logic        iv;
      logic [2:0]  op;
      logic [31:0] vj;
      logic [3:0]  qj;
      logic [31:0] vk;
      logic [3:0]  qk;
      logic [3:0]  dest;
      logic        cv;
      logic [3:0]  ct;
      logic [31:0] cd;
      logic        dr;
      logic        e_ir;
      logic        e_dv;
      logic [2:0]  e_op;
      logic [31:0] e_vj;
      logic [31:0] e_vk;
      logic [3:0]  e_dest;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs [14];

   // Reference model: live ops kept in issue order; the oldest ready one dispatches.
   typedef struct {
      logic [2:0]  op;
      logic [31:0] vj;
      logic [3:0]  qj;
      logic [31:0] vk;
      logic [3:0]  qk;
      logic [3:0]  dest;
   } op_t;

   op_t mq[$];

   function automatic int m_pick();
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].qj == 4'd0 && mq[i].qk == 4'd0) return i;
      end
      return -1;
   endfunction

   task automatic m_compare();
      int p;
      p = m_pick();
      check("rnd_issue_ready", 32'(bus.issue_ready), 32'(mq.size() < N));
      check("rnd_busy_cnt", 32'(busy_cnt), 32'(mq.size()));
      check("rnd_disp_valid", 32'(bus.disp_valid), 32'(p >= 0));
      if (p >= 0) begin
         check("rnd_disp_op", 32'(bus.disp_op), 32'(mq[p].op));
         check("rnd_disp_vj", bus.disp_vj, mq[p].vj);
         check("rnd_disp_vk", bus.disp_vk, mq[p].vk);
         check("rnd_disp_dest", 32'(bus.disp_dest), 32'(mq[p].dest));
      end
   endtask

   task automatic m_step();
      int  p;
      int  n;
      op_t o;
      p = m_pick();
      n = mq.size();
      if (flush) begin
         mq.delete();
      end else begin
         if (p >= 0 && bus.disp_ready) mq.delete(p);
         if (bus.cdb_valid && bus.cdb_tag != 4'd0) begin
            for (int i = 0; i < mq.size(); i++) begin
               if (mq[i].qj == bus.cdb_tag) begin mq[i].vj = bus.cdb_data; mq[i].qj = 4'd0; end
               if (mq[i].qk == bus.cdb_tag) begin mq[i].vk = bus.cdb_data; mq[i].qk = 4'd0; end
            end
         end
         if (bus.issue_valid && n < N) begin
            o = '{op: bus.issue_op, vj: bus.issue_vj, qj: bus.issue_qj,
                  vk: bus.issue_vk, qk: bus.issue_qk, dest: bus.issue_dest};
            if (bus.cdb_valid && bus.cdb_tag != 4'd0) begin
               if (o.qj == bus.cdb_tag) begin o.vj = bus.cdb_data; o.qj = 4'd0; end
               if (o.qk == bus.cdb_tag) begin o.vk = bus.cdb_data; o.qk = 4'd0; end
            end
            mq.push_back(o);
         end
      end
   endtask

   initial begin
      //          fl    iv    op    vj        qj    vk        qk    dest  cv    ct    cd          dr    e_ir  e_dv  e_op  e_vj      e_vk      e_dest e_cnt
      vecs[0]  = '{1'b0, 1'b1, 3'd1, 32'h11,   4'd0, 32'h22,   4'd0, 4'd1, 1'b0, 4'd0, 32'h0,      1'b1, 1'b1, 1'b1, 3'd1, 32'h11,   32'h22,   4'd1,  3'd1};
      vecs[1]  = '{1'b0, 1'b0, 3'd0, 32'h0,    4'd0, 32'h0,    4'd0, 4'd0, 1'b0, 4'd0, 32'h0,      1'b1, 1'b1, 1'b0, 3'd0, 32'h0,    32'h0,    4'd0,  3'd0};
      vecs[2]  = '{1'b0, 1'b1, 3'd2, 32'h0,    4'd3, 32'h33,   4'd0, 4'd2, 1'b0, 4'd0, 32'h0,      1'b1, 1'b1, 1'b0, 3'd0, 32'h0,    32'h0,    4'd0,  3'd1};
      vecs[3]  = '{1'b0, 1'b0, 3'd0, 32'h0,    4'd0, 32'h0,    4'd0, 4'd0, 1'b1, 4'd3, 32'h55,     1'b1, 1'b1, 1'b1, 3'd2, 32'h55,   32'h33,   4'd2,  3'd1};
      vecs[4]  = '{1'b0, 1'b0, 3'd0, 32'h0,    4'd0, 32'h0,    4'd0, 4'd0, 1'b0, 4'd0, 32'h0,      1'b1, 1'b1, 1'b0, 3'd0, 32'h0,    32'h0,    4'd0,  3'd0};
      vecs[5]  = '{1'b0, 1'b1, 3'd3, 32'h0,    4'd5, 32'h44,   4'd0, 4'd3, 1'b1, 4'd5, 32'hAA,     1'b0, 1'b1, 1'b1, 3'd3, 32'hAA,   32'h44,   4'd3,  3'd1};
      vecs[6]  = '{1'b0, 1'b1, 3'd4, 32'h66,   4'd0, 32'h77,   4'd0, 4'd4, 1'b0, 4'd0, 32'h0,      1'b1, 1'b1, 1'b1, 3'd4, 32'h66,   32'h77,   4'd4,  3'd1};
      vecs[7]  = '{1'b0, 1'b1, 3'd5, 32'h12,   4'd0, 32'h13,   4'd0, 4'd5, 1'b1, 4'd0, 32'hDEAD,   1'b0, 1'b1, 1'b1, 3'd4, 32'h66,   32'h77,   4'd4,  3'd2};
      vecs[8]  = '{1'b0, 1'b0, 3'd0, 32'h0,    4'd0, 32'h0,    4'd0, 4'd0, 1'b0, 4'd0, 32'h0,      1'b1, 1'b1, 1'b1, 3'd5, 32'h12,   32'h13,   4'd5,  3'd1};
      vecs[9]  = '{1'b0, 1'b0, 3'd0, 32'h0,    4'd0, 32'h0,    4'd0, 4'd0, 1'b0, 4'd0, 32'h0,      1'b1, 1'b1, 1'b0, 3'd0, 32'h0,    32'h0,    4'd0,  3'd0};
      vecs[10] = '{1'b0, 1'b1, 3'd6, 32'h0,    4'd6, 32'h0,    4'd7, 4'd6, 1'b0, 4'd6, 32'hBB,     1'b1, 1'b1, 1'b0, 3'd0, 32'h0,    32'h0,    4'd0,  3'd1};
      vecs[11] = '{1'b0, 1'b0, 3'd0, 32'h0,    4'd0, 32'h0,    4'd0, 4'd0, 1'b1, 4'd6, 32'hCC,     1'b1, 1'b1, 1'b0, 3'd0, 32'h0,    32'h0,    4'd0,  3'd1};
      vecs[12] = '{1'b0, 1'b0, 3'd0, 32'h0,    4'd0, 32'h0,    4'd0, 4'd0, 1'b1, 4'd7, 32'hDD,     1'b1, 1'b1, 1'b1, 3'd6, 32'hCC,   32'hDD,   4'd6,  3'd1};
      vecs[13] = '{1'b1, 1'b1, 3'd7, 32'h1,    4'd0, 32'h2,    4'd0, 4'd7, 1'b0, 4'd0, 32'h0,      1'b0, 1'b1, 1'b0, 3'd0, 32'h0,    32'h0,    4'd0,  3'd0};

      idle();
      #1 rst_n = 1'b0;
      #2;
      check_out("reset", 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd0);
      check("reset_disp_vj_zero", bus.disp_vj, 32'h0);
      check("reset_disp_dest_zero", 32'(bus.disp_dest), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed vector table.
      for (int v = 0; v < 14; v++) begin
         idle();
         flush          = vecs[v].fl;
         bus.disp_ready = vecs[v].dr;
         if (vecs[v].iv) set_issue(vecs[v].op, vecs[v].vj, vecs[v].qj, vecs[v].vk, vecs[v].qk, vecs[v].dest);
         if (vecs[v].cv) set_cdb(vecs[v].ct, vecs[v].cd);
         tick();
         check_out($sformatf("vec%0d", v), vecs[v].e_ir, vecs[v].e_dv, vecs[v].e_op,
                   vecs[v].e_vj, vecs[v].e_vk, vecs[v].e_dest, vecs[v].e_cnt);
      end

      // Fill all slots with waiting ops, then make slot 0 the youngest.
      for (int d = 1; d <= 4; d++) begin
         idle();
         set_issue(3'(d), 32'h0, 4'(6 + d), 32'h100 + 32'(d), 4'd0, 4'(d));
         tick();
      end
      check_out("full", 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd4);
      idle(); set_cdb(4'd7, 32'h70); tick();
      check_out("wake_first", 1'b0, 1'b1, 3'd1, 32'h70, 32'h101, 4'd1, 3'd4);
      idle(); bus.disp_ready = 1'b1; tick();
      check_out("free_slot0", 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd3);
      idle(); set_issue(3'd5, 32'h0, 4'd9, 32'h105, 4'd0, 4'd5); tick();
      check_out("refill", 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd4);
      idle(); set_issue(3'd6, 32'h6, 4'd0, 32'h106, 4'd0, 4'd6); tick();
      check_out("issue_when_full", 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd4);
      idle(); set_cdb(4'd9, 32'h99); tick();
      check_out("oldest_first", 1'b0, 1'b1, 3'd3, 32'h99, 32'h103, 4'd3, 3'd4);
      idle(); bus.disp_ready = 1'b1; tick();
      check_out("then_younger", 1'b1, 1'b1, 3'd5, 32'h99, 32'h105, 4'd5, 3'd3);
      idle(); bus.disp_ready = 1'b1; tick();
      check_out("two_left", 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd2);

      // Stall: the presented op must hold while the FU refuses it.
      idle(); set_cdb(4'd10, 32'hA0); tick();
      check_out("stall_start", 1'b1, 1'b1, 3'd4, 32'hA0, 32'h104, 4'd4, 3'd2);
      for (int c = 0; c < 5; c++) begin
         idle(); tick();
         check_out($sformatf("stall%0d", c), 1'b1, 1'b1, 3'd4, 32'hA0, 32'h104, 4'd4, 3'd2);
      end
      idle(); flush = 1'b1; tick();
      check_out("flush", 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd0);

      // Asynchronous reset with three ops resident.
      for (int d = 1; d <= 3; d++) begin
         idle(); set_issue(3'(d), 32'(d), 4'd0, 32'(d), 4'd0, 4'(d)); tick();
      end
      idle();
      check_out("pre_reset", 1'b1, 1'b1, 3'd1, 32'h1, 32'h1, 4'd1, 3'd3);
      #2 rst_n = 1'b0;
      #1;
      check_out("async_reset", 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 4'd0, 3'd0);
      check("async_reset_disp_op", 32'(bus.disp_op), 32'h0);
      check("async_reset_disp_vj", bus.disp_vj, 32'h0);
      check("async_reset_disp_vk", bus.disp_vk, 32'h0);
      check("async_reset_disp_dest", 32'(bus.disp_dest), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Randomized traffic against the queue model.
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         m_compare();
         idle();
         flush          = ($urandom % 64) == 0;
         bus.disp_ready = ($urandom % 4) != 0;
         if ($urandom % 3 != 0) begin
            set_issue(3'($urandom), $urandom,
                      ($urandom % 2) ? 4'd0 : 4'(1 + $urandom % 6),
                      $urandom,
                      ($urandom % 2) ? 4'd0 : 4'(1 + $urandom % 6),
                      4'(1 + $urandom % 15));
         end
         if ($urandom % 2) set_cdb(4'($urandom % 7), $urandom);
         m_step();
         tick();
      end
      m_compare();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
